execute_memory_skid: RTL and testbench
======================================

Name: execute_memory_skid

Overview:
- Registered hand-off between the execute stage and the memory stage.
- Captures the ALU result and ALU flags (zero, branch) together with the control and payload that travel with them.
- Provides a 2-entry skid buffer so the execute stage can be stalled by a registered ready, without a combinational path from the memory stage.
- Supports a pipeline flush from the hazard/branch logic and counts back-pressure cycles for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of the ALU result and store data.
- REG_ADDR_WIDTH, 5, width of the destination register index.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  kills every buffered and incoming entry this cycle.
- ex_valid  input  1  execute stage presents a valid entry.
- ex_ready  output  1  buffer can accept; registered (equals !skid_valid).
- ex_alu_result  input  DATA_WIDTH  ALU result.
- ex_zero  input  1  ALU zero flag.
- ex_branch  input  1  ALU branch-condition flag.
- ex_store_data  input  DATA_WIDTH  rs2 value for stores.
- ex_rd  input  REG_ADDR_WIDTH  destination register.
- ex_mem_read  input  1  load control.
- ex_mem_write  input  1  store control.
- ex_reg_write  input  1  writeback enable.
- mem_valid  output  1  head entry valid.
- mem_ready  input  1  memory stage accepts the head entry.
- mem_alu_result, mem_zero, mem_branch, mem_store_data, mem_rd, mem_mem_read, mem_mem_write, mem_reg_write  output  (widths as inputs)  head entry fields.
- stall_count  output  CNT_WIDTH  saturating count of cycles with mem_valid & !mem_ready.

Behaviour:
- Storage:
  - Main slot: main_valid + payload. Skid slot: skid_valid + payload.
  - Outputs are driven from the main slot only; mem_valid = main_valid.
- Reset (async):
  - main_valid = skid_valid = 0, so mem_valid = 0 and ex_ready = 1.
  - All payload registers clear to 0; stall_count = 0.
- Transfer definitions:
  - accept = ex_valid & ex_ready.
  - drain = main_valid & mem_ready.
- Next-state rules when flush = 0, evaluated in order:
  - Main empty and accept: incoming loads main.
  - Main full, drain, skid full: skid moves to main, skid clears. No accept is possible because ex_ready = 0.
  - Main full, drain, skid empty, accept: incoming loads main.
  - Main full, drain, skid empty, no accept: main_valid clears.
  - Main full, no drain, accept: incoming loads skid, so ex_ready falls next cycle.
  - Otherwise: hold.
- Latency and throughput:
  - Incoming entry is visible on mem_* one cycle after accept when the buffer is empty.
  - Full throughput of one entry per cycle while mem_ready stays high.
- Ordering: strictly FIFO. The skid entry is always younger than the main entry.
- Flush:
  - Same-edge clear of main_valid and skid_valid.
  - Any entry accepted in the flush cycle is discarded.
  - Payload registers may hold stale values; only valid bits matter.
  - flush dominates all simultaneous accept/drain events.
  - ex_ready is 1 in the cycle after a flush.
- Payload bookkeeping:
  - Payload registers load only on capture; no enable toggling when empty.
  - zero and branch are passed through unmodified.
  - Branch redirection is decided upstream; this block does not act on mem_branch.
- stall_count:
  - Increments each cycle that mem_valid & !mem_ready.
  - Saturates at all-ones; it does not wrap.
  - Cleared only by reset; unaffected by flush.
- Invariants:
  - skid_valid implies main_valid.
  - Never more than two entries held.
  - No entry duplicated or dropped, except on flush.

Decomposition:
- Shared package/header:
  - Payload field widths and the packed payload width (2*DATA_WIDTH + REG_ADDR_WIDTH + 5).
  - Control-bit ordering within the packed payload.
- One natural sub-module, skid_slot: a payload register with load enable and a valid bit, instantiated twice. The top level holds the control logic and the counter.

Test Plan:
- Reset: assert reset mid-stream with both slots full → mem_valid = 0, ex_ready = 1, stall_count = 0 immediately, with no clock edge required.
- Streaming: mem_ready = 1, ex_valid every cycle with results 0x1,0x2,0x3,0x4 → same sequence on mem_alu_result, one cycle later, one per cycle, ex_ready stays 1.
- Back-pressure: send 0xA,0xB,0xC with mem_ready = 0 from cycle 1 → main = 0xA, skid = 0xB, ex_ready = 0, 0xC held upstream. Then raise mem_ready → outputs 0xA,0xB,0xC in order, with no loss or duplication.
- Flush: both slots full, then flush = 1 with ex_valid = 1 carrying 0xDEAD → next cycle mem_valid = 0, ex_ready = 1, and 0xDEAD never appears.
- Flags/control: ex_zero = 1, ex_branch = 1, rd = 5'd31, mem_write = 1, store_data = 0xFFFFFFFF → identical values on mem_* fields.
- Counter saturation: CNT_WIDTH = 4, hold mem_valid = 1 and mem_ready = 0 for 20 cycles → stall_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/execute_memory_skid_pkg.sv
// Shared payload layout for the execute-to-memory hand-off buffer.
// Control bits occupy the low end of the packed payload, then rd, store data, ALU result.
package execute_memory_skid_pkg;

    localparam int unsigned CTRL_BITS = 5;

    localparam int unsigned CTRL_REG_WRITE = 0;
    localparam int unsigned CTRL_MEM_WRITE = 1;
    localparam int unsigned CTRL_MEM_READ  = 2;
    localparam int unsigned CTRL_BRANCH    = 3;
    localparam int unsigned CTRL_ZERO      = 4;

    function automatic int unsigned payload_width(input int unsigned data_w,
                                                  input int unsigned addr_w);
        return 2 * data_w + addr_w + CTRL_BITS;
    endfunction

endpackage

// File: rtl/execute_memory_skid_slot.sv
// One buffer entry: payload register captured on load, plus its valid bit.
module skid_slot
    import execute_memory_skid_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_d_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/execute_memory_skid.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer, flush and a
// saturating back-pressure counter. ex_ready is registered (= !skid_valid).
module execute_memory_skid
    import execute_memory_skid_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic                      ex_zero,
    input  logic                      ex_branch,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic                      ex_reg_write,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_alu_result,
    output logic                      mem_zero,
    output logic                      mem_branch,
    output logic [DATA_WIDTH-1:0]     mem_store_data,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output logic                      mem_mem_read,
    output logic                      mem_mem_write,
    output logic                      mem_reg_write,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam int unsigned PW      = payload_width(DATA_WIDTH, REG_ADDR_WIDTH);
    localparam int unsigned RD_LSB  = CTRL_BITS;
    localparam int unsigned ST_LSB  = RD_LSB + REG_ADDR_WIDTH;
    localparam int unsigned ALU_LSB = ST_LSB + DATA_WIDTH;

    logic [PW-1:0] ex_payload;
    logic [PW-1:0] main_in;
    logic [PW-1:0] main_data;
    logic [PW-1:0] skid_data;
    logic          main_valid, skid_valid;
    logic          main_valid_d, skid_valid_d;
    logic          main_load, skid_load, main_from_skid;
    logic          accept, drain;

    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    assign ex_payload = {ex_alu_result, ex_store_data, ex_rd,
                         ex_zero, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write};

    assign ex_ready = ~skid_valid;
    assign accept   = ex_valid & ex_ready;
    assign drain    = main_valid & mem_ready;

    always_comb begin
        main_valid_d   = main_valid;
        skid_valid_d   = skid_valid;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_load    = 1'b1;
                main_valid_d = 1'b1;
            end
        end else if (drain) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_valid_d   = 1'b0;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    assign main_in = main_from_skid ? skid_data : ex_payload;

    skid_slot #(.WIDTH(PW)) u_main (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (main_load),
        .data_i    (main_in),
        .valid_d_i (main_valid_d),
        .data_o    (main_data),
        .valid_o   (main_valid)
    );

    skid_slot #(.WIDTH(PW)) u_skid (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (skid_load),
        .data_i    (ex_payload),
        .valid_d_i (skid_valid_d),
        .data_o    (skid_data),
        .valid_o   (skid_valid)
    );

    always_comb begin
        stall_count_d = stall_count_q;
        if (main_valid && !mem_ready && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count    = stall_count_q;
    assign mem_valid      = main_valid;
    assign mem_alu_result = main_data[ALU_LSB +: DATA_WIDTH];
    assign mem_store_data = main_data[ST_LSB +: DATA_WIDTH];
    assign mem_rd         = main_data[RD_LSB +: REG_ADDR_WIDTH];
    assign mem_zero       = main_data[CTRL_ZERO];
    assign mem_branch     = main_data[CTRL_BRANCH];
    assign mem_mem_read   = main_data[CTRL_MEM_READ];
    assign mem_mem_write  = main_data[CTRL_MEM_WRITE];
    assign mem_reg_write  = main_data[CTRL_REG_WRITE];

endmodule

// File: tb/tb_execute_memory_skid.sv
// Directed bench for execute_memory_skid: table-driven streaming/back-pressure/flush
// vectors plus hand sequences for field pass-through, async reset and counter saturation.
module tb_execute_memory_skid;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic        ex_zero;
    logic        ex_branch;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_alu_result;
    logic        mem_zero;
    logic        mem_branch;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_reg_write;
    logic [3:0]  stall_count;

    int checks = 0;
    int errors = 0;
    logic dead_seen = 1'b0;

    always #5 clock = ~clock;

    execute_memory_skid #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .CNT_WIDTH      (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_result  (ex_alu_result),
        .ex_zero        (ex_zero),
        .ex_branch      (ex_branch),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_alu_result (mem_alu_result),
        .mem_zero       (mem_zero),
        .mem_branch     (mem_branch),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .stall_count    (stall_count)
    );

    always @(negedge clock) begin
        if (mem_valid && mem_alu_result == 32'hDEAD) dead_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ex_valid;
        logic [31:0] alu;
        logic        mem_ready;
        logic        flush;
        logic        exp_valid;
        logic [31:0] exp_alu;
        logic        exp_ready;
        logic [3:0]  exp_stall;
    } vec_t;

    vec_t vecs[17];

    task automatic idle_inputs();
        flush         = 1'b0;
        ex_valid      = 1'b0;
        ex_alu_result = '0;
        ex_zero       = 1'b0;
        ex_branch     = 1'b0;
        ex_store_data = '0;
        ex_rd         = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        mem_ready     = 1'b0;
    endtask

    initial begin
        // streaming
        vecs[0]  = '{1'b1, 32'h1,    1'b1, 1'b0, 1'b1, 32'h1,  1'b1, 4'd0};
        vecs[1]  = '{1'b1, 32'h2,    1'b1, 1'b0, 1'b1, 32'h2,  1'b1, 4'd0};
        vecs[2]  = '{1'b1, 32'h3,    1'b1, 1'b0, 1'b1, 32'h3,  1'b1, 4'd0};
        vecs[3]  = '{1'b1, 32'h4,    1'b1, 1'b0, 1'b1, 32'h4,  1'b1, 4'd0};
        vecs[4]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd0};
        // back-pressure: 0xC held upstream while ex_ready is low
        vecs[5]  = '{1'b1, 32'hA,    1'b0, 1'b0, 1'b1, 32'hA,  1'b1, 4'd0};
        vecs[6]  = '{1'b1, 32'hB,    1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 4'd1};
        vecs[7]  = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 4'd2};
        vecs[8]  = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 32'hB,  1'b1, 4'd2};
        vecs[9]  = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 32'hC,  1'b1, 4'd2};
        vecs[10] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd2};
        // flush with both slots full and a live incoming entry
        vecs[11] = '{1'b1, 32'h11,   1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 4'd2};
        vecs[12] = '{1'b1, 32'h22,   1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 4'd3};
        vecs[13] = '{1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 4'd4};
        vecs[14] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd4};
        vecs[15] = '{1'b1, 32'h33,   1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 4'd4};
        vecs[16] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4'd4};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("reset_ex_ready", {31'b0, ex_ready}, 32'h1);
        check("reset_stall", {28'b0, stall_count}, 32'h0);
        check("reset_alu", mem_alu_result, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            ex_valid      = vecs[i].ex_valid;
            ex_alu_result = vecs[i].alu;
            mem_ready     = vecs[i].mem_ready;
            flush         = vecs[i].flush;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_mem_valid", i), {31'b0, mem_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_ex_ready", i), {31'b0, ex_ready}, {31'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d_stall", i), {28'b0, stall_count}, {28'b0, vecs[i].exp_stall});
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_alu", i), mem_alu_result, vecs[i].exp_alu);
        end
        check("dead_never_seen", {31'b0, dead_seen}, 32'h0);

        // field pass-through and control-bit ordering
        @(negedge clock);
        idle_inputs();
        ex_valid = 1'b1; ex_alu_result = 32'h1234_5678; ex_zero = 1'b1; ex_branch = 1'b1;
        ex_rd = 5'd31; ex_mem_write = 1'b1; ex_store_data = 32'hFFFF_FFFF; mem_ready = 1'b1;
        @(posedge clock);
        #1;
        check("f1_alu", mem_alu_result, 32'h1234_5678);
        check("f1_zero", {31'b0, mem_zero}, 32'h1);
        check("f1_branch", {31'b0, mem_branch}, 32'h1);
        check("f1_rd", {27'b0, mem_rd}, 32'd31);
        check("f1_store", mem_store_data, 32'hFFFF_FFFF);
        check("f1_ctrl", {29'b0, mem_mem_read, mem_mem_write, mem_reg_write}, 32'b010);
        @(negedge clock);
        ex_alu_result = 32'h0; ex_zero = 1'b0; ex_branch = 1'b0; ex_rd = 5'd6;
        ex_mem_write = 1'b0; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_store_data = 32'h0F0F_0001;
        @(posedge clock);
        #1;
        check("f2_alu", mem_alu_result, 32'h0);
        check("f2_flags", {30'b0, mem_zero, mem_branch}, 32'b00);
        check("f2_rd", {27'b0, mem_rd}, 32'd6);
        check("f2_store", mem_store_data, 32'h0F0F_0001);
        check("f2_ctrl", {29'b0, mem_mem_read, mem_mem_write, mem_reg_write}, 32'b101);

        // async reset with both slots full, checked before any clock edge
        @(negedge clock);
        idle_inputs();
        ex_valid = 1'b1; ex_alu_result = 32'h55;
        @(posedge clock);
        #1;
        check("prereset_valid", {31'b0, mem_valid}, 32'h1);
        @(negedge clock);
        ex_alu_result = 32'h66;
        @(posedge clock);
        #1;
        check("prereset_ready", {31'b0, ex_ready}, 32'h0);
        @(negedge clock);
        idle_inputs();
        @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("async_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("async_ex_ready", {31'b0, ex_ready}, 32'h1);
        check("async_stall", {28'b0, stall_count}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // counter saturation: one entry held with mem_ready low
        @(negedge clock);
        ex_valid = 1'b1; ex_alu_result = 32'h77;
        @(posedge clock);
        #1;
        check("sat_start", {28'b0, stall_count}, 32'h0);
        @(negedge clock);
        ex_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("sat_k%0d", k), {28'b0, stall_count}, (k > 15) ? 32'd15 : 32'(k));
        end
        check("sat_head_kept", mem_alu_result, 32'h77);

        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        check("flush_keeps_stall", {28'b0, stall_count}, 32'd15);
        check("flush_ready", {31'b0, ex_ready}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
